pipe_stage_fifo: RTL and testbench
==================================

Name: pipe_stage_fifo

Overview:
- Parametrised elastic pipeline-stage register for the in-order RISC-V core; successor to the fixed if_id / id_ex / ex_mem / mem_wb latches.
- Carries an opaque packed payload (any stage struct, cast to WIDTH bits) under a valid/ready handshake.
- Stores up to DEPTH entries, so a downstream stall does not force the upstream stage to stall in the same cycle.
- Supports a synchronous flush for branch/exception squash, and presents an all-zero bubble when empty.

Parameters:
- WIDTH, 161: payload width in bits; 161 fits one if_id entry (inst_signal + inst + inst_pc); legal range ≥1.
- DEPTH, 2: number of entries; must be a power of two, 1..16.
- BYPASS_READY, 1: 1 gives in_ready = !full | out_ready (pop-and-push when full); 0 gives in_ready = !full (registered ready, no combinational path from out_ready).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all stored entries.
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  WIDTH  payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes head this cycle.
- out_data  out  WIDTH  head payload; all zeros when !out_valid.
- count  out  $clog2(DEPTH+1)  number of stored entries.

Behaviour:
- Storage and pointers:
  - Circular buffer of DEPTH x WIDTH.
  - rd_ptr and wr_ptr are log2(DEPTH) bits, wrapping modulo DEPTH.
  - count is a separate register, 0..DEPTH; full = (count==DEPTH), empty = (count==0).
- Reset (reset low, asynchronous):
  - rd_ptr=0, wr_ptr=0, count=0.
  - Outputs: out_valid=0, out_data=0, in_ready=1.
  - Storage contents need not be cleared.
  - Release is synchronous to clk; first push is possible on the first edge after release.
- Handshake:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_valid must not depend on in_ready.
  - Once in_valid is asserted, in_data is held until accepted (upstream rule; the bench checks it).
- Latency:
  - A push at edge N is visible on out_data/out_valid after edge N (one-cycle latency).
  - No same-cycle fall-through from in_data to out_data at any DEPTH.
- Ordering: strict FIFO.
- Head output:
  - out_valid = !empty.
  - out_data = mem[rd_ptr] when out_valid, else all zeros (bubble, equivalent to inst_signal=0).
- Count update, no flush:
  - push & !pop: +1.
  - pop & !push: −1.
  - push & pop: unchanged; write goes to wr_ptr, read advances rd_ptr.
- Full boundary:
  - BYPASS_READY=1: in_ready=1 while full iff out_ready; the simultaneous push/pop keeps count=DEPTH.
  - BYPASS_READY=0: in_ready=0 while full, regardless of out_ready.
- Empty boundary: out_ready while empty is ignored; no underflow, rd_ptr does not move.
- Flush (highest priority, synchronous):
  - At the edge, count=0 and rd_ptr=wr_ptr=0.
  - Any push in the same cycle is discarded.
  - Any pop in the same cycle is still reported to downstream as a handshake; downstream must qualify it with its own flush.
  - in_ready is not gated by flush.
- Wrap-around: pointer increment from DEPTH−1 returns to 0; count is unaffected.
- DEPTH=1: behaves as a classic pipeline register. With BYPASS_READY=1 it gives full throughput under continuous flow; with BYPASS_READY=0 it gives half throughput.
- Reset asserted mid-operation: all entries are lost immediately, asynchronously; outputs return to reset values within the same cycle.

Test Plan:
1. DEPTH=2, BYPASS_READY=1, out_ready=1; push 0x11, 0x22, 0x33 on consecutive cycles -> each appears on out_data one cycle later, in order, and count stays at 1.
2. DEPTH=4, out_ready=0; push 0xA0..0xA4 -> 0xA0..0xA3 accepted, count=4, in_ready=0 on the fifth (BYPASS_READY=0). Then out_ready=1 -> outputs A0, A1, A2, A3, after which out_valid=0 and out_data=0.
3. DEPTH=2, BYPASS_READY=1, full with {1,2}; in_valid=1 with data 3, out_ready=1 -> pop 1 and push 3 in the same cycle, count stays 2, subsequent outputs are 2 then 3. Repeat with BYPASS_READY=0 -> in_ready=0 and 3 is not accepted that cycle.
4. DEPTH=4 holding 3 entries; assert flush with in_valid=1 (data 0x55) -> next cycle count=0, out_valid=0, and 0x55 never appears.
5. DEPTH=4; 10 push/pop pairs with ptr wrap, values 0..9 -> output sequence 0..9 exactly, count never exceeds 4.
6. Hold count=3; drive reset low between clock edges -> out_valid=0, count=0 and out_data=0 immediately. After release, push 0x7 -> out_data=0x7 one cycle later.

Source files
------------

// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline-stage register: DEPTH-entry circular buffer under a valid/ready
// handshake, with synchronous squash and an all-zero bubble when empty.
module pipe_stage_fifo #(
  parameter int WIDTH        = 161,
  parameter int DEPTH        = 2,
  parameter int BYPASS_READY = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Pointers wrap modulo DEPTH, which need not fill the pointer's binary range.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign out_valid = !empty;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign in_ready  = (BYPASS_READY != 0) ? (!full || out_ready) : !full;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; a squashed push must not land in the buffer.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Directed bench for pipe_stage_fifo: three instances cover DEPTH/BYPASS_READY
// combinations; each scenario task checks hand-computed values inline.
module tb_pipe_stage_fifo;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // a: DEPTH=2, BYPASS_READY=1, default WIDTH
  logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [160:0] a_in_data, a_out_data;
  logic [1:0]   a_count;
  // b: DEPTH=4, BYPASS_READY=0
  logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0]  b_in_data, b_out_data;
  logic [2:0]   b_count;
  // c: DEPTH=2, BYPASS_READY=0
  logic         c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [15:0]  c_in_data, c_out_data;
  logic [1:0]   c_count;

  pipe_stage_fifo #(.WIDTH(161), .DEPTH(2), .BYPASS_READY(1)) u_a (
    .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .count(a_count));

  pipe_stage_fifo #(.WIDTH(16), .DEPTH(4), .BYPASS_READY(0)) u_b (
    .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .count(b_count));

  pipe_stage_fifo #(.WIDTH(16), .DEPTH(2), .BYPASS_READY(0)) u_c (
    .clk(clk), .reset(reset), .flush(c_flush), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .in_data(c_in_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .count(c_count));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_a_valid got=%0b exp=0", a_out_valid); end
    n_checks++; if (a_out_data !== '0) begin n_fail++; $display("[TB] FAIL rst_a_data got=%0h exp=0", a_out_data); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_a_in_ready got=%0b exp=1", a_in_ready); end
    n_checks++; if (b_count !== 3'd0) begin n_fail++; $display("[TB] FAIL rst_b_count got=%0d exp=0", b_count); end
    n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_b_in_ready got=%0b exp=1", b_in_ready); end
    n_checks++; if (c_count !== 2'd0) begin n_fail++; $display("[TB] FAIL rst_c_count got=%0d exp=0", c_count); end
    reset = 1'b1;
  endtask

  task automatic test_stream();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    a_out_ready = 1'b1;
    a_in_valid  = 1'b0;
    tick();
    n_checks++; if (a_count !== 2'd0) begin n_fail++; $display("[TB] FAIL empty_pop_count got=%0d exp=0", a_count); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL empty_pop_valid got=%0b exp=0", a_out_valid); end
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 161'(vals[i]);
      tick();
      n_checks++; if (a_out_data !== 161'(vals[i])) begin n_fail++; $display("[TB] FAIL stream_data got=%0h exp=%0h", a_out_data, vals[i]); end
      n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_valid got=%0b exp=1", a_out_valid); end
      n_checks++; if (a_count !== 2'd1) begin n_fail++; $display("[TB] FAIL stream_count got=%0d exp=1", a_count); end
    end
    a_in_valid = 1'b0;
    tick();
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_end_valid got=%0b exp=0", a_out_valid); end
    n_checks++; if (a_out_data !== '0) begin n_fail++; $display("[TB] FAIL stream_end_data got=%0h exp=0", a_out_data); end
    a_out_ready = 1'b0;
  endtask

  task automatic test_fill_drain();
    b_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 16'hA0 + 16'(i);
      tick();
    end
    n_checks++; if (b_count !== 3'd4) begin n_fail++; $display("[TB] FAIL fill_count got=%0d exp=4", b_count); end
    n_checks++; if (b_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_in_ready got=%0b exp=0", b_in_ready); end
    b_in_data = 16'hA4;
    tick();
    n_checks++; if (b_count !== 3'd4) begin n_fail++; $display("[TB] FAIL overflow_count got=%0d exp=4", b_count); end
    n_checks++; if (b_out_data !== 16'hA0) begin n_fail++; $display("[TB] FAIL overflow_head got=%0h exp=a0", b_out_data); end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    #1;
    n_checks++; if (b_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_noby_in_ready got=%0b exp=0", b_in_ready); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (b_out_data !== 16'hA0 + 16'(i)) begin n_fail++; $display("[TB] FAIL drain_data got=%0h exp=%0h", b_out_data, 16'hA0 + 16'(i)); end
      n_checks++; if (b_out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_valid got=%0b exp=1", b_out_valid); end
      tick();
    end
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_end_valid got=%0b exp=0", b_out_valid); end
    n_checks++; if (b_out_data !== 16'h0) begin n_fail++; $display("[TB] FAIL drain_end_data got=%0h exp=0", b_out_data); end
    n_checks++; if (b_count !== 3'd0) begin n_fail++; $display("[TB] FAIL drain_end_count got=%0d exp=0", b_count); end
    b_out_ready = 1'b0;
  endtask

  task automatic test_full_bypass();
    a_out_ready = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 161'(i);
      tick();
    end
    a_in_data   = 161'd3;
    a_out_ready = 1'b1;
    #1;
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL byp_in_ready got=%0b exp=1", a_in_ready); end
    n_checks++; if (a_out_data !== 161'd1) begin n_fail++; $display("[TB] FAIL byp_head got=%0h exp=1", a_out_data); end
    tick();
    n_checks++; if (a_count !== 2'd2) begin n_fail++; $display("[TB] FAIL byp_count got=%0d exp=2", a_count); end
    n_checks++; if (a_out_data !== 161'd2) begin n_fail++; $display("[TB] FAIL byp_data2 got=%0h exp=2", a_out_data); end
    a_in_valid = 1'b0;
    tick();
    n_checks++; if (a_out_data !== 161'd3) begin n_fail++; $display("[TB] FAIL byp_data3 got=%0h exp=3", a_out_data); end
    n_checks++; if (a_count !== 2'd1) begin n_fail++; $display("[TB] FAIL byp_count1 got=%0d exp=1", a_count); end
    tick();
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL byp_end_valid got=%0b exp=0", a_out_valid); end
    a_out_ready = 1'b0;

    c_out_ready = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      c_in_valid = 1'b1;
      c_in_data  = 16'(i);
      tick();
    end
    c_in_data   = 16'd3;
    c_out_ready = 1'b1;
    #1;
    n_checks++; if (c_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL noby_in_ready got=%0b exp=0", c_in_ready); end
    tick();
    n_checks++; if (c_count !== 2'd1) begin n_fail++; $display("[TB] FAIL noby_count got=%0d exp=1", c_count); end
    n_checks++; if (c_out_data !== 16'd2) begin n_fail++; $display("[TB] FAIL noby_data2 got=%0h exp=2", c_out_data); end
    tick();
    n_checks++; if (c_out_data !== 16'd3) begin n_fail++; $display("[TB] FAIL noby_data3 got=%0h exp=3", c_out_data); end
    n_checks++; if (c_count !== 2'd1) begin n_fail++; $display("[TB] FAIL noby_count1 got=%0d exp=1", c_count); end
    c_in_valid = 1'b0;
    tick();
    n_checks++; if (c_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL noby_end_valid got=%0b exp=0", c_out_valid); end
    c_out_ready = 1'b0;
  endtask

  task automatic test_flush();
    b_out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 16'(i * 16'h10);
      tick();
    end
    n_checks++; if (b_count !== 3'd3) begin n_fail++; $display("[TB] FAIL flush_pre_count got=%0d exp=3", b_count); end
    b_flush   = 1'b1;
    b_in_data = 16'h55;
    tick();
    b_flush    = 1'b0;
    b_in_valid = 1'b0;
    n_checks++; if (b_count !== 3'd0) begin n_fail++; $display("[TB] FAIL flush_count got=%0d exp=0", b_count); end
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_valid got=%0b exp=0", b_out_valid); end
    n_checks++; if (b_out_data !== 16'h0) begin n_fail++; $display("[TB] FAIL flush_data got=%0h exp=0", b_out_data); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_ghost got=%0b exp=0 data=%0h", b_out_valid, b_out_data); end
    end
    b_in_valid = 1'b1;
    b_in_data  = 16'h66;
    tick();
    b_in_valid = 1'b0;
    n_checks++; if (b_out_data !== 16'h66) begin n_fail++; $display("[TB] FAIL flush_after_data got=%0h exp=66", b_out_data); end
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    n_checks++; if (b_count !== 3'd0) begin n_fail++; $display("[TB] FAIL flush_after_count got=%0d exp=0", b_count); end
  endtask

  task automatic test_wrap();
    b_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 16'(i);
      tick();
      n_checks++; if (b_out_data !== 16'(i)) begin n_fail++; $display("[TB] FAIL wrap_data got=%0h exp=%0h", b_out_data, i); end
      n_checks++; if (b_count !== 3'd1) begin n_fail++; $display("[TB] FAIL wrap_count got=%0d exp=1", b_count); end
    end
    b_in_valid = 1'b0;
    tick();
    n_checks++; if (b_count !== 3'd0) begin n_fail++; $display("[TB] FAIL wrap_end_count got=%0d exp=0", b_count); end
    b_out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 3; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 16'(i);
      tick();
    end
    b_in_valid = 1'b0;
    n_checks++; if (b_count !== 3'd3) begin n_fail++; $display("[TB] FAIL arst_pre_count got=%0d exp=3", b_count); end
    #1 reset = 1'b0;
    #1;
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_valid got=%0b exp=0", b_out_valid); end
    n_checks++; if (b_count !== 3'd0) begin n_fail++; $display("[TB] FAIL arst_count got=%0d exp=0", b_count); end
    n_checks++; if (b_out_data !== 16'h0) begin n_fail++; $display("[TB] FAIL arst_data got=%0h exp=0", b_out_data); end
    #2 reset = 1'b1;
    b_in_valid = 1'b1;
    b_in_data  = 16'h7;
    tick();
    b_in_valid = 1'b0;
    n_checks++; if (b_out_data !== 16'h7) begin n_fail++; $display("[TB] FAIL arst_push_data got=%0h exp=7", b_out_data); end
    n_checks++; if (b_count !== 3'd1) begin n_fail++; $display("[TB] FAIL arst_push_count got=%0d exp=1", b_count); end
  endtask

  initial begin
    reset = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
    c_flush = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0; c_in_data = '0;
    test_reset();
    test_stream();
    test_fill_drain();
    test_full_bypass();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
